// File: rtl/apb_pkg.sv
// Shared state encoding and width defaults for the APB requester.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB requester: single-beat valid/ready commands become APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout is built in when APB_MASTER_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0, exactly one cycle
// ACCESS | psel=1, penable=1 until pready (or timeout)
// RESP   | rsp_valid=1, fields held until rsp_ready
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    apb_master_state_t     state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Down-counter loaded on ACCESS entry; terminal count 1 means this is the last allowed cycle.
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !preset;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_cnt_d = TMO_W'(TIMEOUT_CYCLES);
`endif
            end

            ACCESS: begin
                // pready takes priority over an expiring timeout on the same edge
                if (pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (tmo_cnt_q == TMO_W'(1)) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
`endif
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, hand-written corner sequences,
// and randomized transfers against a memory-level reference model.
module tb_apb_master_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;

    initial forever #5 pclk = ~pclk;

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // APB slave + bus monitor, evaluated on the falling edge
    logic [DW-1:0] slv_mem [logic [AW-1:0]];
    int            cur_waits = 0;
    bit            cur_err = 1'b0;
    int            acc_cnt = 0;
    int            psel_cnt = 0;
    int            pen_cnt = 0;
    bit            cap_valid = 1'b0;
    bit            unstable = 1'b0;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic          cap_write;

    initial forever begin
        @(negedge pclk);
        if (psel === 1'b1) begin
            if (!cap_valid) begin
                cap_addr  = paddr;
                cap_wdata = pwdata;
                cap_write = pwrite;
                cap_valid = 1'b1;
            end else if (paddr !== cap_addr || pwdata !== cap_wdata || pwrite !== cap_write) begin
                unstable = 1'b1;
            end
            psel_cnt++;
            if (penable === 1'b1) pen_cnt++;
        end
        if (psel === 1'b1 && penable === 1'b1 && !preset) begin
            if (acc_cnt == cur_waits) begin
                pready  = 1'b1;
                pslverr = cur_err;
                if (pwrite) begin
                    prdata = $urandom;
                    if (!cur_err) slv_mem[paddr] = pwdata;
                end else begin
                    prdata = slv_mem.exists(paddr) ? slv_mem[paddr] : '0;
                end
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata  = $urandom;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end
    end

    // Reference model: flat memory, updated only by writes that complete without error
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic bit tmo_expected(input int waits);
        return TMO_EN && (waits >= TMO);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic model_commit(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input bit err, input bit tmo);
        if (w && !err && !tmo) ref_mem[a] = d;
    endtask

    // One complete transfer; entered and left on a falling edge.
    task automatic xfer(input string tag, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int waits, input bit err, input int hold,
                        input bit keep, input logic [DW-1:0] exp_rdata, input bit exp_err,
                        input bit exp_tmo);
        int t;
        int lat;
        int exp_lat;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cur_waits = waits;
        cur_err   = err;
        psel_cnt  = 0;
        pen_cnt   = 0;
        cap_valid = 1'b0;
        unstable  = 1'b0;
        rsp_ready = 1'b0;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge pclk);
            t++;
        end
        chk({tag, ".accept"}, 64'(cmd_ready), 64'(1));
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge pclk);
        lat = 1;
        if (keep) begin
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end else begin
            cmd_valid = 1'b0;
        end
        if (hold == 0) rsp_ready = 1'b1;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            @(negedge pclk);
            lat++;
        end
        exp_lat = exp_tmo ? 2 + TMO : 3 + waits;
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".psel_cycles"}, 64'(psel_cnt), 64'(exp_tmo ? TMO + 1 : waits + 2));
        chk({tag, ".penable_cycles"}, 64'(pen_cnt), 64'(exp_tmo ? TMO : waits + 1));
        chk({tag, ".paddr"}, 64'(cap_addr), 64'(a));
        chk({tag, ".pwrite_pwdata"}, 64'({cap_write, cap_wdata}), 64'({w, w ? d : 32'h0}));
        chk({tag, ".bus_stable"}, 64'(unstable), 64'(0));
        chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
        chk({tag, ".rsp_err_tmo"}, 64'({rsp_err, rsp_timeout}), 64'({exp_err, exp_tmo}));
        for (int i = 0; i < hold; i++) begin
            chk({tag, ".hold"}, 64'({rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_rdata}),
                64'({1'b1, 1'b0, exp_err, exp_tmo, exp_rdata}));
            @(negedge pclk);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk({tag, ".after_handshake"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    endtask

    task automatic run_model(input string tag, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int waits, input bit err,
                             input int hold, input bit keep);
        bit            tmo;
        logic [DW-1:0] er;
        tmo = tmo_expected(waits);
        er  = (w || tmo) ? '0 : ref_read(a);
        xfer(tag, w, a, d, waits, err, hold, keep, er, err || tmo, tmo);
        model_commit(w, a, d, err, tmo);
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            waits;
        bit            err;
        int            hold;
        bit            keep;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 32'd5,     32'hDEADBEEF, 0, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'd5,     32'h0,        0, 1'b0, 0, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b0, 32'd5,     32'h0,        3, 1'b0, 0, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 32'd40,    32'h12345678, 0, 1'b1, 0, 1'b0, 32'h0,        1'b1};
        tbl[4] = '{1'b0, 32'd40,    32'h0,        1, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        tbl[5] = '{1'b1, 32'h100,   32'hA5A5A5A5, 2, 1'b0, 5, 1'b1, 32'h0,        1'b0};
        tbl[6] = '{1'b0, 32'h100,   32'h0,        0, 1'b0, 0, 1'b1, 32'hA5A5A5A5, 1'b0};
        tbl[7] = '{1'b0, 32'd5,     32'h0,        0, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[8] = '{1'b1, 32'd7,     32'hCAFEF00D, 0, 1'b0, 2, 1'b1, 32'h0,        1'b0};
        tbl[9] = '{1'b0, 32'd7,     32'h0,        2, 1'b1, 1, 1'b0, 32'hCAFEF00D, 1'b1};

        repeat (2) @(negedge pclk);
        chk("reset_ctrl", 64'({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, rsp_timeout}),
            64'(0));
        chk("reset_data", 64'({paddr, pwdata}), 64'(0));
        chk("reset_rdata", 64'(rsp_rdata), 64'(0));
        preset = 1'b0;
        @(negedge pclk);
        chk("idle_ready", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 10; i++) begin
            xfer($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].err,
                 tbl[i].hold, tbl[i].keep, tbl[i].exp_rdata, tbl[i].exp_err, 1'b0);
            model_commit(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].err, 1'b0);
        end

        // Asynchronous reset in the middle of ACCESS wait states
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        cur_waits = 1000;
        cur_err   = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_pre_access", 64'({psel, penable}), 64'(2'b11));
        #2 preset = 1'b1;
        #1;
        chk("rst_async", 64'({psel, penable, rsp_valid, cmd_ready}), 64'(0));
        @(negedge pclk);
        chk("rst_held", 64'({psel, penable, pwrite, rsp_valid, cmd_ready, rsp_err, rsp_timeout}),
            64'(0));
        preset = 1'b0;
        @(negedge pclk);
        chk("rst_release", 64'({cmd_ready, psel, rsp_valid}), 64'(3'b100));
        run_model("rst_read0", 1'b0, 32'h0, 32'h0, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            run_model($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                      int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 3)), (i < 39) && ($urandom_range(0, 1) == 1));
        end

`ifdef APB_MASTER_TIMEOUT_EN
        run_model("tmo_never", 1'b0, 32'h8, 32'h0, 1000, 1'b0, 1, 1'b0);
        run_model("tmo_tie", 1'b0, 32'h8, 32'h0, TMO - 1, 1'b0, 0, 1'b0);
        run_model("tmo_write", 1'b1, 32'hC, 32'h55AA55AA, 1000, 1'b0, 0, 1'b0);
        run_model("tmo_after", 1'b0, 32'hC, 32'h0, 0, 1'b0, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester: turns single-beat commands from a local valid/ready port into APB SETUP/ACCESS transfers.
- Returns read data and the error status on a valid/ready response port.
- Sits between testbench or CPU-side logic and the APB memory slave on the same pclk domain.
- One outstanding transfer at a time.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/paddr
DATA_WIDTH, 32, width of write/read data
TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit (used only with APB_MASTER_TIMEOUT_EN), must be >= 1

Ports:
pclk  in  1  single clock, rising edge
preset  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB slave ready
pslverr  in  1  APB slave error
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_err  out  1  slave error or timeout
rsp_timeout  out  1  transfer ended by timeout

Behaviour:
- Interface decision: one clock, pclk; reset is asynchronous and active-high, port preset.
- Reset, asserted at any time and including mid-transfer:
  - state goes to IDLE immediately.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - cmd_ready is 0 while preset is high.
  - An in-flight transfer is dropped with no response.
- All outputs are registered except cmd_ready, which is (state==IDLE) && !preset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, capture cmd_write, cmd_addr and cmd_wdata into paddr/pwrite/pwdata; go to SETUP.
  - pwdata is loaded with 0 for reads.
- SETUP: psel=1, penable=0; exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite and pwdata are held stable.
  - Stays in ACCESS while pready=0.
  - On the edge where pready=1:
    - capture rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr.
    - drop psel and penable to 0; go to RESP.
- RESP:
  - rsp_valid=1; all fields held until rsp_ready=1.
  - On handshake: rsp_valid=0; go to IDLE.
  - A rsp_ready already high on the first RESP cycle completes the handshake that cycle.
- Latency:
  - Accept at edge N: SETUP in cycle N+1, ACCESS in N+2.
  - pready sampled at edge N+2+W (W = wait cycles, 0 or more): rsp_valid in cycle N+3+W.
  - Minimum command-to-command spacing is 4 cycles.
- pready/pslverr/prdata are ignored outside ACCESS.
- cmd_valid while not in IDLE is held off by cmd_ready=0; the master never drops or queues a command.
- No address range checking in the master; the slave decides pslverr.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, abort: psel=penable=0, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A pready arriving on the same edge as the limit wins (normal completion, rsp_timeout=0).
- Not defined:
  - ACCESS waits indefinitely.
  - rsp_timeout is tied 0 and no counter logic exists.

Decomposition:
- Shared package apb_pkg:
  - typedef enum apb_master_state_t {IDLE, SETUP, ACCESS, RESP}.
  - APB_ADDR_WIDTH=32 and APB_DATA_WIDTH=32 as defaults for the parameters.
- Single module, no sub-module; the timeout counter is inline.

Test Plan:
- Write then read:
  - Write addr=5, data=32'hDEADBEEF with pready=1 on the first ACCESS cycle.
  - Required: psel 2 cycles, penable 1 cycle, rsp_err=0.
  - Reading addr=5 then returns rsp_rdata=32'hDEADBEEF.
- Wait states: read with pready held low 3 ACCESS cycles -> penable high 4 cycles, paddr stable, rsp_valid 1 cycle after pready.
- Slave error: write addr=40 with pslverr=1 alongside pready -> rsp_err=1, rsp_rdata=0; the next command is accepted normally.
- Response backpressure:
  - rsp_ready held low 5 cycles -> rsp_valid and fields stable, cmd_ready=0 throughout.
  - Back-to-back cmd_valid -> second command accepted exactly 1 cycle after the response handshake.
- Reset mid-ACCESS: assert preset between edges during wait states -> psel/penable/rsp_valid go 0 without waiting for a clock edge; after release, a read of addr=0 completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - pready never asserted -> after 4 ACCESS cycles, rsp_err=1 and rsp_timeout=1.
  - pready on the 4th cycle -> normal completion with rsp_timeout=0.
